// File: rtl/tmr_pkg.sv
// Shared constants, register layout and FSM state type for the timer device.
package tmr_pkg;

    localparam int unsigned DW     = 32;
    localparam int unsigned PS_W   = 8;
    localparam int unsigned CTRL_W = 4;

    localparam logic [1:0] A_CTRL   = 2'd0;
    localparam logic [1:0] A_PRESET = 2'd1;
    localparam logic [1:0] A_COUNT  = 2'd2;
    localparam logic [1:0] A_PS     = 2'd3;

    localparam int unsigned CTRL_EN   = 0;
    localparam int unsigned CTRL_MODE = 1;
    localparam int unsigned CTRL_IM   = 3;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    // Field order mirrors the CTRL bit indices above
    typedef struct packed {
        logic       im;
        logic [1:0] mode;
        logic       en;
    } ctrl_t;

    typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} tmr_state_e;

    // Only the 01 encoding reloads; 00/10/11 all behave as one-shot
    function automatic logic is_reload(input ctrl_t c);
        return c.mode == MODE_RELOAD;
    endfunction

endpackage

// File: rtl/timer_dev_if.sv
// Bridge-to-timer port: word address, write strobe/data, read data and IRQ.
interface timer_dev_if;
    import tmr_pkg::*;

    logic [1:0]    addr;
    logic          we;
    logic [DW-1:0] din;
    logic [DW-1:0] dout;
    logic          irq;

    modport master (output addr, we, din, input dout, irq);
    modport slave  (input addr, we, din, output dout, irq);
endinterface

// File: rtl/tmr_prescaler.sv
// Count-enable tick generator: fires every ps_i+1 run cycles, restarted by clr_i.
// Only present when TMR_PRESCALE_EN is defined.
`ifdef TMR_PRESCALE_EN
module tmr_prescaler
    import tmr_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            clr_i,
    input  logic            run_i,
    input  logic [PS_W-1:0] ps_i,
    output logic            tick_c_o
);

    logic [PS_W-1:0] cnt_q;

    // >= so a PRESCALE rewrite below the running count cannot stall the tick
    assign tick_c_o = (cnt_q >= ps_i);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (run_i) begin
            cnt_q <= tick_c_o ? '0 : cnt_q + PS_W'(1);
        end
    end

endmodule
`endif

// File: rtl/timer_dev.sv
// Programmable down-counter timer with one-shot / auto-reload modes and level IRQ.
// Define TMR_PRESCALE_EN to add the R/W PRESCALE register at addr 3 and the tick prescaler.
module timer_dev
    import tmr_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    timer_dev_if.slave  bus
);

    ctrl_t         ctrl_q;
    ctrl_t         ctrl_d;
    logic [DW-1:0] preset_q;
    logic [DW-1:0] count_q;
    logic          pend_q;
    tmr_state_e    state_q;
    logic          wr_ctrl_c;
    logic          wr_preset_c;
    logic          tick_c;

    assign wr_ctrl_c   = bus.we && (bus.addr == A_CTRL);
    assign wr_preset_c = bus.we && (bus.addr == A_PRESET);

    // CTRL as it will be after this edge, so a same-edge write overrides the FSM
    assign ctrl_d = wr_ctrl_c ? ctrl_t'(bus.din[CTRL_W-1:0]) : ctrl_q;

`ifdef TMR_PRESCALE_EN
    logic [PS_W-1:0] ps_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ps_q <= '0;
        end else if (bus.we && (bus.addr == A_PS)) begin
            ps_q <= bus.din[PS_W-1:0];
        end
    end

    tmr_prescaler u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (state_q == LOAD),
        .run_i    (state_q == CNT),
        .ps_i     (ps_q),
        .tick_c_o (tick_c)
    );
`else
    assign tick_c = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_q   <= '0;
            preset_q <= '0;
            count_q  <= '0;
            pend_q   <= 1'b0;
            state_q  <= IDLE;
        end else begin
            if (wr_ctrl_c) begin
                ctrl_q <= ctrl_d;
            end
            if (wr_preset_c) begin
                preset_q <= bus.din;
            end

            case (state_q)
                IDLE: begin
                    if (ctrl_d.en) begin
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    count_q <= preset_q;
                    pend_q  <= 1'b0;
                    state_q <= CNT;
                end
                CNT: begin
                    if (!ctrl_d.en) begin
                        state_q <= IDLE;
                    end else if (tick_c) begin
                        if (count_q <= DW'(1)) begin
                            count_q <= '0;
                            state_q <= INT;
                        end else begin
                            count_q <= count_q - DW'(1);
                        end
                    end
                end
                INT: begin
                    if (wr_ctrl_c) begin
                        state_q <= IDLE;
                    end else begin
                        pend_q <= 1'b1;
                        if (is_reload(ctrl_q)) begin
                            state_q <= LOAD;
                        end else begin
                            ctrl_q.en <= 1'b0;
                            state_q   <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase

            // Register writes take priority over any pend update above
            if (wr_ctrl_c || wr_preset_c) begin
                pend_q <= 1'b0;
            end
        end
    end

    always_comb begin
        bus.dout = '0;
        case (bus.addr)
            A_CTRL:   bus.dout = {{(DW-CTRL_W){1'b0}}, ctrl_q};
            A_PRESET: bus.dout = preset_q;
            A_COUNT:  bus.dout = count_q;
`ifdef TMR_PRESCALE_EN
            A_PS:     bus.dout = {{(DW-PS_W){1'b0}}, ps_q};
`else
            A_PS:     bus.dout = '0;
`endif
            default:  bus.dout = '0;
        endcase
    end

    assign bus.irq = ctrl_q.im & pend_q;

endmodule

// File: tb/tb_timer_dev.sv
// Randomized self-checking bench for timer_dev against a closed-form timing model.
module tb_timer_dev;
    import tmr_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    timer_dev_if bus ();

    timer_dev u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [DW-1:0] d);
        bus.addr = a;
        bus.din  = d;
        bus.we   = 1'b1;
        step();
        bus.we   = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [DW-1:0] d);
        bus.addr = a;
        #1;
        d = bus.dout;
    endtask

    task automatic check_cycle(input string tag, input int exp_cnt, input logic exp_irq);
        logic [DW-1:0] v;
        rd(A_COUNT, v);
        chk({tag, "_count"}, v, DW'(exp_cnt));
        chk({tag, "_irq"}, DW'(bus.irq), DW'(exp_irq));
    endtask

    task automatic stop_timer();
        wr(A_CTRL, '0);
        step();
        step();
    endtask

    function automatic logic [DW-1:0] ctrl_word(input logic im, input logic [1:0] mode, input logic en);
        return DW'({im, mode, en});
    endfunction

    // Non-reload run: COUNT = p..1 then 0, irq from edge max(p,1)+2 onward, EN self-clears
    task automatic run_oneshot(input int p, input logic [1:0] mode, input logic im);
        logic [DW-1:0] v;
        int pe;
        pe = (p < 1) ? 1 : p;
        wr(A_PRESET, DW'(p));
        wr(A_CTRL, ctrl_word(im, mode, 1'b1));
        for (int j = 1; j <= pe + 4; j++) begin
            step();
            check_cycle("oneshot", (j <= p) ? (p - j + 1) : 0, im && (j >= pe + 2));
        end
        rd(A_CTRL, v);
        chk("oneshot_ctrl_en_cleared", v, ctrl_word(im, mode, 1'b0));
        wr(A_CTRL, ctrl_word(im, mode, 1'b0));
        chk("oneshot_irq_cleared", DW'(bus.irq), '0);
    endtask

    // Reload run: period max(p,1)+2 cycles, irq high only in the last phase of each period
    task automatic run_reload(input int p, input logic im, input int periods);
        int pe;
        int len;
        int m;
        pe  = (p < 1) ? 1 : p;
        len = pe + 2;
        wr(A_PRESET, DW'(p));
        wr(A_CTRL, ctrl_word(im, MODE_RELOAD, 1'b1));
        for (int j = 1; j <= periods * len; j++) begin
            step();
            m = (j - 1) % len;
            check_cycle("reload", (m < pe) ? (p - m) : 0, im && (m == pe + 1));
        end
        stop_timer();
        chk("reload_stop_irq", DW'(bus.irq), '0);
    endtask

    // Disable while COUNT reads f, expect freeze, then re-enable reloads PRESET
    task automatic run_freeze(input int p, input int f);
        wr(A_PRESET, DW'(p));
        wr(A_CTRL, ctrl_word(1'b1, MODE_ONESHOT, 1'b1));
        for (int j = 1; j <= p - f + 1; j++) begin
            step();
            check_cycle("freeze_run", p - j + 1, 1'b0);
        end
        wr(A_CTRL, ctrl_word(1'b1, MODE_ONESHOT, 1'b0));
        for (int k = 0; k < 4; k++) begin
            check_cycle("freeze_hold", f, 1'b0);
            step();
        end
        wr(A_CTRL, ctrl_word(1'b1, MODE_ONESHOT, 1'b1));
        step();
        check_cycle("freeze_reload", p, 1'b0);
        stop_timer();
    endtask

    // Disable exactly on the terminal-count edge (at_int=0) or on the INT edge (at_int=1)
    task automatic run_collision(input int p, input logic at_int);
        logic [DW-1:0] v;
        int n;
        n = at_int ? p + 1 : p;
        wr(A_PRESET, DW'(p));
        wr(A_CTRL, ctrl_word(1'b1, MODE_ONESHOT, 1'b1));
        for (int j = 1; j <= n; j++) begin
            step();
        end
        wr(A_CTRL, ctrl_word(1'b1, MODE_ONESHOT, 1'b0));
        for (int k = 0; k < 4; k++) begin
            chk(at_int ? "coll_int_irq" : "coll_tc_irq", DW'(bus.irq), '0);
            step();
        end
        rd(A_CTRL, v);
        chk("coll_ctrl", v, ctrl_word(1'b1, MODE_ONESHOT, 1'b0));
        stop_timer();
    endtask

    task automatic check_all_zero(input string tag);
        logic [DW-1:0] v;
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), v);
            chk(tag, v, '0);
        end
        chk({tag, "_irq"}, DW'(bus.irq), '0);
    endtask

    initial begin
        logic [DW-1:0] v;
        int p;
        int r;
        logic [1:0] md;

        bus.addr = A_CTRL;
        bus.we   = 1'b0;
        bus.din  = '0;

        #2;
        check_all_zero("reset_regs");
        @(negedge clk);
        rst = 1'b1;
        step();

        wr(A_COUNT, DW'(32'hDEAD_BEEF));
        rd(A_COUNT, v);
        chk("count_write_ignored", v, '0);

        run_oneshot(5, MODE_ONESHOT, 1'b1);
        run_oneshot(0, MODE_ONESHOT, 1'b1);
        run_oneshot(1, 2'b11, 1'b1);
        for (int i = 0; i < 4; i++) begin
            p  = int'($urandom_range(0, 9));
            r  = int'($urandom_range(0, 2));
            md = (r == 0) ? MODE_ONESHOT : 2'(r + 1);
            run_oneshot(p, md, 1'($urandom_range(0, 1)));
        end

        run_reload(3, 1'b1, 4);
        for (int i = 0; i < 3; i++) begin
            run_reload(int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)), 2);
        end

        run_freeze(10, 6);
        p = int'($urandom_range(6, 12));
        run_freeze(p, int'($urandom_range(2, p)));

        run_collision(4, 1'b0);
        run_collision(3, 1'b1);
        run_collision(int'($urandom_range(2, 8)), 1'($urandom_range(0, 1)));

        // Asynchronous reset in the middle of a count
        wr(A_PRESET, DW'($urandom_range(8, 20)));
        wr(A_CTRL, ctrl_word(1'b1, MODE_RELOAD, 1'b1));
        step();
        step();
        step();
        #1;
        rst = 1'b0;
        #1;
        check_all_zero("midreset_regs");
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check_cycle("post_reset", 0, 1'b0);
        end

`ifdef TMR_PRESCALE_EN
        wr(A_PS, DW'(2));
        rd(A_PS, v);
        chk("ps_readback", v, DW'(2));
        wr(A_PRESET, DW'(2));
        wr(A_CTRL, ctrl_word(1'b1, MODE_ONESHOT, 1'b1));
        // one decrement per 3 clocks: terminal reached at edge 7, irq from edge 8
        for (int j = 1; j <= 10; j++) begin
            step();
            r = (j - 1) / 3;
            check_cycle("prescale", (r >= 2) ? 0 : 2 - r, j >= 8);
        end
        stop_timer();
`else
        wr(A_PS, DW'(8'hFF));
        rd(A_PS, v);
        chk("ps_absent_reads_zero", v, '0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
